exact_mult_3x3: RTL and testbench
=================================

# exact_mult_3x3

Exact signed 3x3-bit multiplier, the accurate baseline against which the team's approximate multipliers are compared. It produces the full 6-bit two's-complement product combinationally and also offers an optional registered copy with a valid flag for pipelined use. The product is built structurally as a Baugh-Wooley partial-product array with explicit adders, with no behavioural `*`, so the gate-level structure matches the approximate variants.

## Interface
- WIDTH, 3, operand width in bits (signed); product width is 2*WIDTH. Only 3 is required to pass sign-off; the array generation must stay parametric.
- clk  input  1  single clock; all sequential logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  qualifies a/b for the registered path.
- a  input  WIDTH  signed multiplicand, two's complement.
- b  input  WIDTH  signed multiplier, two's complement.
- y  output  2*WIDTH  signed product a*b, purely combinational.
- y_q  output  2*WIDTH  registered product (see Configuration).
- out_valid  output  1  qualifies y_q.

## Operation
- y = a*b exactly for all 64 operand pairs. Operand range is -4..3; product range is -12..16.
- 16 (from -4*-4) fits in 6-bit signed. No overflow or saturation is possible.
- Baugh-Wooley array structure:
  - Partial product pp[i][j] = a[j] & b[i].
  - Terms with exactly one sign bit (i or j = WIDTH-1, not both) are inverted.
  - pp[W-1][W-1] is not inverted.
  - Constant 1 is added at bit positions WIDTH and 2*WIDTH-1.
- Reduction uses a carry-save array of half/full-adder cells, then a ripple-carry final adder. Each cell is its own instance or generate element.
- The carry out of bit 2*WIDTH-1 is discarded.
- y has no dependence on clk, rst_n or in_valid. y settles within one combinational path of an operand change.
- Registered path, when compiled in:
  - On each rising clk: y_q <= y and out_valid <= in_valid.
  - y_q loads every cycle regardless of in_valid. Consumers must qualify it with out_valid.

## Timing
- y: zero-cycle latency. Sampling y at the same edge that launches new a/b returns the product of the previous operands.
- y_q/out_valid (macro defined): 1-cycle latency. Operands present before edge N appear on y_q after edge N.
- Reset:
  - rst_n low forces y_q = 0 and out_valid = 0 immediately, without waiting for clk.
  - Both hold while rst_n is low.
  - First capture occurs on the first rising clk after rst_n deasserts.
  - y is unaffected by reset.
- Reset asserted mid-stream: the pending product is dropped and out_valid falls asynchronously.
- Throughput: one product per cycle with no stall or backpressure.

## Configuration
- EXACT_MULT_OUT_REG_EN defined: the y_q/out_valid register stage is instantiated as described above.
- EXACT_MULT_OUT_REG_EN undefined: no flops are built. y_q is wired to y and out_valid to in_valid, both combinational. clk and rst_n remain as unused ports.

## Test plan
- Exhaustive sweep: all 64 (a,b) pairs. y equals the behavioural signed product every time, e.g. 3*3=9 (001001), -4*3=-12 (110100), -1*-1=1.
- Corner values:
  - a=-4, b=-4 -> y=16 (010000), positive with no wrap.
  - a=0, b=-4 -> y=0.
  - a=-4, b=1 -> y=-4 (111100).
- Random stream, 1000 cycles:
  - a,b driven from $random%4 (values -3..3), updated on the rising clk edge.
  - Compare y to a*b at each edge, checking the product of the previous operands. Must never mismatch.
- Registered path (macro defined):
  - Drive a=2, b=-3, in_valid=1.
  - After the next edge: y_q=-6 (111010), out_valid=1.
  - Drive in_valid=0; the following edge gives out_valid=0.
- Async reset (macro defined):
  - With y_q=9 and out_valid=1, pull rst_n low between edges.
  - y_q=0 and out_valid=0 immediately, while y still shows the live product.
  - After release, the first edge captures normally.
- Macro undefined: y_q tracks y and out_valid tracks in_valid with zero latency, and reset has no effect.

Source files
------------

// File: rtl/exact_mult_3x3.sv
// exact_mult_3x3: exact signed WIDTH x WIDTH multiplier (WIDTH = 3 by default).
// The product is built as a Baugh-Wooley partial-product array reduced by a
// carry-save array of half/full-adder cells and a ripple-carry final adder.
// This keeps its gate-level structure aligned with the approximate variants.
// Optional output register stage: define EXACT_MULT_OUT_REG_EN to build the
// y_q/out_valid flops. Without it, y_q/out_valid are wired straight through.
module exact_mult_3x3 #(
    parameter int unsigned WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   y,
    output logic [2*WIDTH-1:0]   y_q,
    output logic                 out_valid
);

    localparam int unsigned PW = 2 * WIDTH;

    // Baugh-Wooley correction constants: a one at bit WIDTH and at bit PW-1.
    localparam logic [PW-1:0] BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

    // row_vec[i] is partial-product row i, already shifted to weight i.
    logic [WIDTH-1:0][PW-1:0] row_vec;
    // Carry-save state after absorbing rows 0..i: sum vector and carry vector.
    logic [WIDTH-1:0][PW-1:0] s_vec;
    logic [WIDTH-1:0][PW-1:0] c_vec;
    // Ripple carries of the final adder.
    logic [PW-1:0]            rc;

    // ------------------------------------------------------------------
    // Partial-product generation
    // ------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_row
        for (genvar k = 0; k < PW; k++) begin : g_col
            if ((k >= i) && (k < i + WIDTH)) begin : g_pp
                localparam int J = k - i;
                // Exactly one sign bit involved: the term carries negative
                // weight, so it enters the array inverted.
                if ((i == WIDTH - 1) != (J == WIDTH - 1)) begin : g_inv
                    assign row_vec[i][k] = ~(a[J] & b[i]);
                end else begin : g_pos
                    assign row_vec[i][k] = a[J] & b[i];
                end
            end else begin : g_zero
                assign row_vec[i][k] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Carry-save array
    // ------------------------------------------------------------------
    // Row 0 seeds the sum vector; the correction constants seed the carry
    // vector, so they are folded in for free by the first adder row.
    assign s_vec[0] = row_vec[0];
    assign c_vec[0] = BW_CONST;

    for (genvar i = 1; i < WIDTH; i++) begin : g_csa
        assign c_vec[i][0] = 1'b0;
        for (genvar k = 0; k < PW; k++) begin : g_cell
            if ((k >= i) && (k < i + WIDTH)) begin : g_fa
                // Full adder: row bit present in this column.
                assign s_vec[i][k] = s_vec[i-1][k] ^ c_vec[i-1][k] ^ row_vec[i][k];
                if (k < PW - 1) begin : g_co
                    assign c_vec[i][k+1] = (s_vec[i-1][k] & c_vec[i-1][k])
                                         | (s_vec[i-1][k] & row_vec[i][k])
                                         | (c_vec[i-1][k] & row_vec[i][k]);
                end
            end else begin : g_ha
                // Half adder: no partial product in this column for this row.
                assign s_vec[i][k] = s_vec[i-1][k] ^ c_vec[i-1][k];
                if (k < PW - 1) begin : g_co
                    assign c_vec[i][k+1] = s_vec[i-1][k] & c_vec[i-1][k];
                end
            end
            // The carry out of the top column is beyond the product width.
        end
    end

    // ------------------------------------------------------------------
    // Ripple-carry final adder
    // ------------------------------------------------------------------
    assign rc[0] = 1'b0;
    for (genvar k = 0; k < PW; k++) begin : g_rca
        assign y[k] = s_vec[WIDTH-1][k] ^ c_vec[WIDTH-1][k] ^ rc[k];
        if (k < PW - 1) begin : g_co
            assign rc[k+1] = (s_vec[WIDTH-1][k] & c_vec[WIDTH-1][k])
                           | (s_vec[WIDTH-1][k] & rc[k])
                           | (c_vec[WIDTH-1][k] & rc[k]);
        end
        // Carry out of bit PW-1 is discarded; the product cannot overflow.
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
`ifdef EXACT_MULT_OUT_REG_EN
    logic [PW-1:0] prod_d, prod_q;
    logic          valid_d, valid_q;

    // Next state: capture the product every cycle; out_valid qualifies it.
    always_comb begin
        prod_d  = y;
        valid_d = in_valid;
    end

    // Output register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            prod_q  <= prod_d;
            valid_q <= valid_d;
        end
    end

    assign y_q       = prod_q;
    assign out_valid = valid_q;
`else
    // Pass-through: no state, clk and rst_n are intentionally unused.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign y_q       = y;
    assign out_valid = in_valid;
`endif

endmodule

// File: tb/tb_exact_mult_3x3.sv
// Self-checking bench for exact_mult_3x3: exhaustive sweep, corners, a random
// stream with one-edge-late checking, and the output stage in either build.
module tb_exact_mult_3x3;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [2:0]        a;
    logic [2:0]        b;
    logic [5:0]        y;
    logic [5:0]        y_q;
    logic              out_valid;

    int                n_cmp  = 0;
    int                n_fail = 0;
    logic [5:0]        exp_q[$];

    exact_mult_3x3 #(.WIDTH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .y         (y),
        .y_q       (y_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against an expected one.
    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Pop the oldest expected product and compare it against an observed value.
    task automatic check_pop(input string tag, input logic [5:0] obs);
        logic [5:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: observed %b expected <empty scoreboard>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    // Drive operands and push the behavioural product to the scoreboard.
    task automatic drive(input int ai, input int bi);
        a = 3'(ai);
        b = 3'(bi);
        exp_q.push_back(6'(ai * bi));
    endtask

    initial begin
        int ra;
        int rb;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 3'd0;
        b        = 3'd0;
        #2;

`ifdef EXACT_MULT_OUT_REG_EN
        // Reset state, and reset holds across clock edges even with valid input.
        check("rst_y_q", y_q, 6'd0);
        check("rst_out_valid", {5'd0, out_valid}, 6'd0);
        in_valid = 1'b1;
        a        = 3'd3;
        b        = 3'd3;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_y_q", y_q, 6'd0);
        check("rst_hold_out_valid", {5'd0, out_valid}, 6'd0);
        in_valid = 1'b0;
`else
        // Pass-through build: y_q follows y and out_valid follows in_valid.
        drive(-3, 3);
        #1;
        check_pop("pt_y", y);
        check("pt_y_q_rst", y_q, 6'b110111);
        in_valid = 1'b1;
        #1;
        check("pt_valid_rst", {5'd0, out_valid}, 6'd1);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Exhaustive sweep of all 64 operand pairs.
        for (int ai = -4; ai < 4; ai++) begin
            for (int bi = -4; bi < 4; bi++) begin
                drive(ai, bi);
                #1;
                check_pop($sformatf("sweep_%0d_%0d", ai, bi), y);
            end
        end

        // Corner values, expected bits written out directly.
        a = 3'b100; b = 3'b100; #1; check("corner_m4_m4", y, 6'b010000);
        a = 3'b000; b = 3'b100; #1; check("corner_0_m4", y, 6'b000000);
        a = 3'b100; b = 3'b001; #1; check("corner_m4_1", y, 6'b111100);
        a = 3'b011; b = 3'b011; #1; check("corner_3_3", y, 6'b001001);
        a = 3'b100; b = 3'b011; #1; check("corner_m4_3", y, 6'b110100);
        a = 3'b111; b = 3'b111; #1; check("corner_m1_m1", y, 6'b000001);

`ifndef EXACT_MULT_OUT_REG_EN
        // Pass-through tracks y/in_valid with no latency, reset has no effect.
        in_valid = 1'b0;
        #1;
        check("pt_y_q", y_q, 6'b000001);
        check("pt_valid_lo", {5'd0, out_valid}, 6'd0);
        rst_n = 1'b0;
        a = 3'b010; b = 3'b101;
        in_valid = 1'b1;
        #1;
        check("pt_y_q_rst2", y_q, 6'b111010);
        check("pt_valid_rst2", {5'd0, out_valid}, 6'd1);
        rst_n = 1'b1;
`endif

        // Random stream: check at each edge the product of the operands
        // launched at the previous edge, then launch new ones.
        @(posedge clk);
        #1;
        ra = $random % 4;
        rb = $random % 4;
        drive(ra, rb);
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk);
            #1;
            check_pop("rand_y", y);
            ra = $random % 4;
            rb = $random % 4;
            drive(ra, rb);
        end
        #1;
        check_pop("rand_last_y", y);

`ifdef EXACT_MULT_OUT_REG_EN
        // Registered path: one-cycle latency, out_valid follows in_valid.
        @(negedge clk);
        in_valid = 1'b1;
        drive(2, -3);
        @(posedge clk);
        #1;
        check_pop("reg_y_q", y_q);
        check("reg_out_valid", {5'd0, out_valid}, 6'd1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("reg_out_valid_lo", {5'd0, out_valid}, 6'd0);

        // Async reset between edges with a valid product held.
        in_valid = 1'b1;
        a = 3'd3; b = 3'd3;
        @(posedge clk);
        #1;
        check("ar_pre_y_q", y_q, 6'b001001);
        check("ar_pre_valid", {5'd0, out_valid}, 6'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_y_q", y_q, 6'd0);
        check("ar_valid", {5'd0, out_valid}, 6'd0);
        check("ar_live_y", y, 6'b001001);
        #1;
        rst_n = 1'b1;
        #1;
        check("ar_rel_y_q", y_q, 6'd0);
        drive(-4, -4);
        @(posedge clk);
        #1;
        check_pop("ar_first_y_q", y_q);
        check("ar_first_valid", {5'd0, out_valid}, 6'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish by 200000");
        $fatal(1, "timeout");
    end

endmodule
